buffer_sched: RTL and testbench

BUFFER_SCHED -- requirements
Module: buffer_sched

---
 rtl/buffer_sched_pkg.sv | 12 +
 rtl/buffer_sched_rr_pick.sv | 26 ++
 rtl/buffer_sched.sv | 129 ++++++++++++
 tb/tb_buffer_sched.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/buffer_sched_pkg.sv
// Shared types and constants for the buffer scheduler.
package buffer_sched_pkg;

  localparam int unsigned FLIT_W_DEFAULT = 55;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    SEND  = 2'd2
  } state_e;

endpackage

// File: rtl/buffer_sched_rr_pick.sv
// Combinational round-robin search: first occupied port after token, wrapping,
// with the token's own port checked last.
module rr_pick #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] occ,
  input  logic [IDX_W-1:0]     token,
  output logic [IDX_W-1:0]     idx,
  output logic                 found
);

  always_comb begin
    idx   = token;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      logic [IDX_W-1:0] cand;
      cand = IDX_W'((32'(token) + k) % NUM_PORTS);
      if (!found && occ[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/buffer_sched.sv
// Round-robin scheduler of NUM_PORTS external flit buffers onto one output link.
// Optional BUFFER_SCHED_STALL_EN adds a sticky stall_err after STALL_LIMIT stalled SEND cycles.
module buffer_sched
  import buffer_sched_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned FLIT_W    = FLIT_W_DEFAULT
`ifdef BUFFER_SCHED_STALL_EN
  , parameter int unsigned STALL_LIMIT = 1000
`endif
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          in_valid,
  output logic [NUM_PORTS-1:0]          in_ready,
  output logic [NUM_PORTS-1:0]          buffer_select,
  input  logic [NUM_PORTS*FLIT_W-1:0]   buf_q,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [FLIT_W-1:0]             out_flit,
  output logic [$clog2(NUM_PORTS)-1:0]  grant_idx
`ifdef BUFFER_SCHED_STALL_EN
  , output logic                        stall_err
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_PORTS);

  state_e                 state_q, state_d;
  logic [NUM_PORTS-1:0]   occ_q, occ_d, clr;
  logic [IDX_W-1:0]       token_q, token_d;
  logic                   out_valid_q, out_valid_d;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_found;
  logic                   hs;

  // A port is refused while its buffer holds an unsent flit.
  assign in_ready      = ~occ_q;
  assign buffer_select = in_valid & ~occ_q;
  assign hs            = out_valid_q & out_ready;
  assign clr           = hs ? (NUM_PORTS'(1) << token_q) : '0;
  assign occ_d         = (occ_q | buffer_select) & ~clr;

  assign out_valid = out_valid_q;
  assign grant_idx = token_q;
  assign out_flit  = buf_q[token_q*FLIT_W +: FLIT_W];

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr_pick (
    .occ   (occ_q),
    .token (token_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // State register; token resets to the last port so the first search starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      occ_q       <= '0;
      token_q     <= IDX_W'(NUM_PORTS - 1);
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      occ_q       <= occ_d;
      token_q     <= token_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    token_d     = token_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (|occ_q) state_d = GRANT;
      end
      GRANT: begin
        if (pick_found) begin
          token_d     = pick_idx;
          out_valid_d = 1'b1;
          state_d     = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = (|occ_d) ? GRANT : IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

`ifdef BUFFER_SCHED_STALL_EN
  logic [15:0] stall_cnt_q;
  logic        stall_err_q;
  logic        stalled;

  assign stalled   = (state_q == SEND) && !out_ready;
  assign stall_err = stall_err_q;

  // Saturating count of consecutive stalled SEND cycles; error flag is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      stall_err_q <= 1'b0;
    end else begin
      if (hs) begin
        stall_cnt_q <= '0;
      end else if (stalled && stall_cnt_q != 16'hFFFF) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (stalled && (32'(stall_cnt_q) + 32'd1 >= STALL_LIMIT)) begin
        stall_err_q <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_buffer_sched.sv
// Scoreboard bench for buffer_sched; expected (port, flit) pairs are queued at offer time.
`timescale 1ns/1ps
module tb_buffer_sched;

  localparam int unsigned NUM_PORTS = 4;
  localparam int unsigned FLIT_W    = 55;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic [NUM_PORTS-1:0]        in_valid;
  logic [NUM_PORTS-1:0]        in_ready;
  logic [NUM_PORTS-1:0]        buffer_select;
  logic [NUM_PORTS*FLIT_W-1:0] buf_q;
  logic                        out_valid;
  logic                        out_ready;
  logic [FLIT_W-1:0]           out_flit;
  logic [1:0]                  grant_idx;
`ifdef BUFFER_SCHED_STALL_EN
  logic                        stall_err;
`endif

  logic [FLIT_W-1:0] din  [NUM_PORTS];
  logic [FLIT_W-1:0] bufs [NUM_PORTS];
  int                exp_port[$];
  logic [FLIT_W-1:0] exp_data[$];
  int                n_checks = 0;
  int                n_err    = 0;

  always #5 clk = ~clk;

  buffer_sched #(
    .NUM_PORTS (NUM_PORTS),
    .FLIT_W    (FLIT_W)
`ifdef BUFFER_SCHED_STALL_EN
    , .STALL_LIMIT (8)
`endif
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .buffer_select (buffer_select),
    .buf_q         (buf_q),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_flit      (out_flit),
    .grant_idx     (grant_idx)
`ifdef BUFFER_SCHED_STALL_EN
    , .stall_err   (stall_err)
`endif
  );

  // External buffer models loaded by buffer_select.
  always @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++)
      if (buffer_select[i]) bufs[i] <= din[i];
  end

  always_comb begin
    buf_q = '0;
    for (int i = 0; i < NUM_PORTS; i++) buf_q[i*FLIT_W +: FLIT_W] = bufs[i];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop on every output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_port.size() == 0) begin
        check("sb_underflow", 64'(exp_port.size()), 64'(1));
      end else begin
        check("sb_grant", 64'(grant_idx), 64'(exp_port.pop_front()));
        check("sb_flit", 64'(out_flit), 64'(exp_data.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FLIT_W-1:0] rnd();
    return FLIT_W'({$urandom, $urandom});
  endfunction

  task automatic push(input int p);
    exp_port.push_back(p);
    exp_data.push_back(din[p]);
  endtask

  task automatic load(input logic [NUM_PORTS-1:0] mask);
    for (int i = 0; i < NUM_PORTS; i++) if (mask[i]) din[i] = rnd();
  endtask

  task automatic offer(input logic [NUM_PORTS-1:0] mask);
    in_valid = mask;
    tick();
    in_valid = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_port.delete();
    exp_data.delete();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int budget);
    bit got = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    if (!got) check("wait_valid_timeout", 64'(got), 64'(1));
  endtask

  task automatic wait_idle(input int budget);
    bit got = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      @(negedge clk);
      if (!out_valid && in_ready == 4'hF) got = 1'b1;
    end
    if (!got) check("wait_idle_timeout", 64'(got), 64'(1));
  endtask

  task automatic all_four_round(input string tag);
    load(4'hF);
    for (int p = 0; p < NUM_PORTS; p++) push(p);
    offer(4'hF);
    for (int j = 0; j <= 9; j++) begin
      bit exp_v;
      @(negedge clk);
      exp_v = (j >= 2 && j <= 8 && (j % 2) == 0);
      check({tag, "_valid"}, 64'(out_valid), 64'(exp_v));
      if (exp_v) check({tag, "_grant"}, 64'(grant_idx), 64'((j - 2) / 2));
    end
    check({tag, "_occ_empty"}, 64'(in_ready), 64'(4'hF));
  endtask

  initial begin
    logic [FLIT_W-1:0] held;
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      din[i]  = '0;
      bufs[i] = '0;
    end

    // Reset state; buffer_select follows in_valid while held in reset.
    tick();
    in_valid = 4'b0101;
    @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_grant", 64'(grant_idx), 64'(3));
    check("rst_ready", 64'(in_ready), 64'(4'hF));
    check("rst_bsel", 64'(buffer_select), 64'(4'b0101));
`ifdef BUFFER_SCHED_STALL_EN
    check("rst_stall", 64'(stall_err), 64'(0));
`endif
    tick();
    in_valid = '0;
    rst_n    = 1'b1;

    // Single flit on port 0: out_valid two edges after acceptance.
    load(4'b0001);
    push(0);
    in_valid = 4'b0001;
    @(negedge clk);
    check("t1_bsel", 64'(buffer_select), 64'(4'b0001));
    tick();
    in_valid = '0;
    @(negedge clk);
    check("t1_e0_valid", 64'(out_valid), 64'(0));
    check("t1_e0_ready", 64'(in_ready), 64'(4'b1110));
    check("t1_e0_bsel", 64'(buffer_select), 64'(0));
    @(negedge clk);
    check("t1_e1_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    check("t1_e2_valid", 64'(out_valid), 64'(1));
    check("t1_e2_grant", 64'(grant_idx), 64'(0));
    check("t1_e2_flit", 64'(out_flit), 64'(din[0]));
    tick();
    out_ready = 1'b1;
    wait_idle(10);
    out_ready = 1'b0;

    // All four ports at once, two rounds to cover token wrap.
    do_reset();
    out_ready = 1'b1;
    all_four_round("t2a");
    all_four_round("t2b");
    out_ready = 1'b0;

    // Stalled SEND holds outputs; occupied port refuses a new offer.
    do_reset();
    load(4'b0100);
    push(2);
    held = din[2];
    offer(4'b0100);
    wait_valid(8);
    tick();
    din[2]   = rnd();
    in_valid = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("t3_valid", 64'(out_valid), 64'(1));
      check("t3_grant", 64'(grant_idx), 64'(2));
      check("t3_flit", 64'(out_flit), 64'(held));
      check("t3_ready", 64'(in_ready), 64'(4'b1011));
      check("t3_bsel", 64'(buffer_select), 64'(0));
    end
    tick();
    in_valid  = '0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    check("t3_freed_ready", 64'(in_ready), 64'(4'hF));
    check("t3_freed_valid", 64'(out_valid), 64'(0));

    // Token at 1 with ports 1 and 3 occupied: grant 3 first, then 1.
    do_reset();
    out_ready = 1'b1;
    load(4'b0010);
    push(1);
    offer(4'b0010);
    wait_valid(8);
    check("t4_first", 64'(grant_idx), 64'(1));
    wait_idle(10);
    tick();
    load(4'b1010);
    push(3);
    push(1);
    offer(4'b1010);
    wait_valid(8);
    check("t4_second", 64'(grant_idx), 64'(3));
    tick();
    wait_valid(8);
    check("t4_third", 64'(grant_idx), 64'(1));
    wait_idle(10);
    tick();
    out_ready = 1'b0;

    // Asynchronous reset during SEND discards the flit immediately.
    do_reset();
    load(4'b0001);
    push(0);
    offer(4'b0001);
    wait_valid(8);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_valid", 64'(out_valid), 64'(0));
    check("t5_ready", 64'(in_ready), 64'(4'hF));
    check("t5_grant", 64'(grant_idx), 64'(3));
    exp_port.delete();
    exp_data.delete();
    tick();
    rst_n = 1'b1;

`ifdef BUFFER_SCHED_STALL_EN
    // Eight stalled SEND cycles raise stall_err; it stays set after a handshake.
    do_reset();
    load(4'b0001);
    push(0);
    offer(4'b0001);
    wait_valid(8);
    repeat (7) @(negedge clk);
    check("t6_before", 64'(stall_err), 64'(0));
    @(negedge clk);
    check("t6_set", 64'(stall_err), 64'(1));
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    check("t6_sticky", 64'(stall_err), 64'(1));
`endif

    check("sb_left", 64'(exp_port.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
